// File: rtl/dma_req_arbiter.sv
// dma_req_arbiter: packet-granular round-robin merge of the read, write and
// MSI-X request streams into the single AXI-Stream request channel that feeds
// the PCIe request converter. A winning packet keeps the grant until its
// tlast beat is taken. The output is one registered stage that still moves
// one beat per cycle while the downstream converter keeps tready high.
module dma_req_arbiter #(
  parameter int CNT_W        = 16,
  parameter int DMA_DATA_W   = 64,
  parameter int AXIS_TUSER_W = 108,
  parameter int DMA_KEEP_W   = 8
) (
  input  logic                    dma_clk,
  input  logic                    rst_n,
  // ch0: read requests
  input  logic                    rd_req_tvalid,
  input  logic                    rd_req_tlast,
  input  logic [DMA_DATA_W-1:0]   rd_req_tdata,
  input  logic [AXIS_TUSER_W-1:0] rd_req_tuser,
  input  logic [DMA_KEEP_W-1:0]   rd_req_tkeep,
  output logic                    rd_req_tready,
  // ch1: write requests with payload
  input  logic                    wr_req_tvalid,
  input  logic                    wr_req_tlast,
  input  logic [DMA_DATA_W-1:0]   wr_req_tdata,
  input  logic [AXIS_TUSER_W-1:0] wr_req_tuser,
  input  logic [DMA_KEEP_W-1:0]   wr_req_tkeep,
  output logic                    wr_req_tready,
  // ch2: MSI-X interrupt requests
  input  logic                    int_req_tvalid,
  input  logic                    int_req_tlast,
  input  logic [DMA_DATA_W-1:0]   int_req_tdata,
  input  logic [AXIS_TUSER_W-1:0] int_req_tuser,
  input  logic [DMA_KEEP_W-1:0]   int_req_tkeep,
  output logic                    int_req_tready,
  // merged request stream
  output logic                    axis_req_tvalid,
  output logic                    axis_req_tlast,
  output logic [DMA_DATA_W-1:0]   axis_req_tdata,
  output logic [AXIS_TUSER_W-1:0] axis_req_tuser,
  output logic [DMA_KEEP_W-1:0]   axis_req_tkeep,
  input  logic                    axis_req_tready,
  // forwarded-packet counters
  output logic [CNT_W-1:0]        rd_pkt_cnt,
  output logic [CNT_W-1:0]        wr_pkt_cnt,
  output logic [CNT_W-1:0]        int_pkt_cnt
);

  localparam int BEAT_W = DMA_DATA_W + AXIS_TUSER_W + DMA_KEEP_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              full_q, full_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  int_cnt_q, int_cnt_d;

  logic [2:0]        in_valid;
  logic [2:0]        in_last;
  logic [2:0]        in_ready;
  logic [2:0]        in_acc;
  logic [2:0]        blocked;
  logic [2:0]        lock_sel;
  logic [BEAT_W-1:0] in_beat [3];
  logic              stage_ready;
  logic              acc_any;
  logic              acc_last;
  logic [1:0]        acc_ch;

  assign in_valid   = {int_req_tvalid, wr_req_tvalid, rd_req_tvalid};
  assign in_last    = {int_req_tlast, wr_req_tlast, rd_req_tlast};
  assign in_beat[0] = {rd_req_tdata, rd_req_tuser, rd_req_tkeep, rd_req_tlast};
  assign in_beat[1] = {wr_req_tdata, wr_req_tuser, wr_req_tkeep, wr_req_tlast};
  assign in_beat[2] = {int_req_tdata, int_req_tuser, int_req_tkeep, int_req_tlast};

  // The output register can take a beat when empty or when it drains this cycle.
  assign stage_ready = !full_q || axis_req_tready;

  assign rd_req_tready  = in_ready[0];
  assign wr_req_tready  = in_ready[1];
  assign int_req_tready = in_ready[2];

  // At most one channel can be ready with valid high, so the OR is a clean select.
  assign in_acc   = in_valid & in_ready;
  assign acc_any  = |in_acc;
  assign acc_last = |(in_acc & in_last);

  assign {axis_req_tdata, axis_req_tuser, axis_req_tkeep, axis_req_tlast} = beat_q;
  assign axis_req_tvalid = full_q;
  assign rd_pkt_cnt      = rd_cnt_q;
  assign wr_pkt_cnt      = wr_cnt_q;
  assign int_pkt_cnt     = int_cnt_q;

  // Arbitration state register
  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 2'd0;
      ptr_q   <= 2'd2;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: lock onto a multi-beat winner, release on its accepted tlast
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_any) begin
          ptr_d = acc_ch;
          if (!acc_last) begin
            state_d = ST_LOCKED;
            grant_d = acc_ch;
          end
        end
      end
      ST_LOCKED: begin
        if (acc_any && acc_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready outputs: a channel is ready only if no channel ahead of it in the
  // rotation is valid, so its tready never looks at its own tvalid
  always_comb begin
    blocked  = 3'b000;
    lock_sel = 3'b000;
    in_ready = 3'b000;
    case (ptr_q)
      2'd0:    blocked = {in_valid[1], 1'b0, in_valid[1] | in_valid[2]};
      2'd1:    blocked = {1'b0, in_valid[2] | in_valid[0], in_valid[2]};
      default: blocked = {in_valid[0] | in_valid[1], in_valid[0], 1'b0};
    endcase
    for (int i = 0; i < 3; i++) begin
      lock_sel[i] = (grant_q == 2'(i));
    end
    if (state_q == ST_LOCKED) begin
      in_ready = lock_sel & {3{stage_ready}};
    end else begin
      in_ready = ~blocked & {3{stage_ready}};
    end
    if (!rst_n) begin
      in_ready = 3'b000;
    end
  end

  // Encode the accepted channel for the grant/pointer update and the data mux
  always_comb begin
    acc_ch = 2'd0;
    if (in_acc[1]) acc_ch = 2'd1;
    if (in_acc[2]) acc_ch = 2'd2;
  end

  // Output stage: load on input acceptance, clear only on a drain with no load
  always_comb begin
    beat_d = beat_q;
    full_d = full_q && !axis_req_tready;
    if (acc_any) begin
      full_d = 1'b1;
      case (acc_ch)
        2'd1:    beat_d = in_beat[1];
        2'd2:    beat_d = in_beat[2];
        default: beat_d = in_beat[0];
      endcase
    end
  end

  // Output register; cleared on reset so nothing stale is presented afterwards
  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      beat_q <= '0;
    end else begin
      full_q <= full_d;
      beat_q <= beat_d;
    end
  end

  // Per-channel packet counters bump on each accepted tlast beat and wrap freely
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    int_cnt_d = int_cnt_q;
    if (in_acc[0] && in_last[0]) rd_cnt_d  = rd_cnt_q + 1'b1;
    if (in_acc[1] && in_last[1]) wr_cnt_d  = wr_cnt_q + 1'b1;
    if (in_acc[2] && in_last[2]) int_cnt_d = int_cnt_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      int_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      int_cnt_q <= int_cnt_d;
    end
  end

endmodule
